adder_sum_accumulator: RTL and testbench

- Downstream consumer of the registered adder's `sum` output.
- Accumulates a programmable-length block of adder sums into a wider accumulator.
- Presents each block total, sample count and sticky overflow flag on a valid/ready output handshake.
- Used to build multi-stage arithmetic benchmark chains with real control and backpressure.

---
 rtl/adder_sum_accumulator.sv | 160 ++++++++++++++++
 tb/tb_adder_sum_accumulator.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/adder_sum_accumulator.sv
// adder_sum_accumulator: sums programmable-length blocks of adder results
// into a wide accumulator and hands each block total out over valid/ready.
module adder_sum_accumulator #(
  parameter int unsigned SUM_WIDTH = 57,
  parameter int unsigned ACC_WIDTH = 64,
  parameter int unsigned LEN_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [SUM_WIDTH-1:0] in_sum,
  input  logic [LEN_WIDTH-1:0] block_len,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_acc,
  output logic [LEN_WIDTH:0]   out_count,
  output logic                 out_overflow,
  output logic                 busy
);

  localparam int unsigned CNT_WIDTH = LEN_WIDTH + 1;
  localparam int unsigned EXT_WIDTH = ACC_WIDTH + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;

  logic [ACC_WIDTH-1:0]   r_acc;
  logic [CNT_WIDTH-1:0]   r_cnt;
  logic [CNT_WIDTH-1:0]   r_len;
  logic                   r_ovf;

  logic                   r_out_valid;
  logic [ACC_WIDTH-1:0]   r_out_acc;
  logic [CNT_WIDTH-1:0]   r_out_count;
  logic                   r_out_ovf;

  logic                   w_in_ready;
  logic                   w_busy;
  logic                   w_accept;
  logic                   w_xfer;
  logic                   w_start;
  logic                   w_done;
  logic [CNT_WIDTH-1:0]   w_len_dec;
  logic [EXT_WIDTH-1:0]   w_sum_ext;
  logic [ACC_WIDTH-1:0]   w_new_acc;
  logic [CNT_WIDTH-1:0]   w_new_cnt;
  logic [CNT_WIDTH-1:0]   w_new_len;
  logic                   w_new_ovf;

  // Handshake qualifiers and the per-sample datapath update.
  always_comb begin
    w_accept  = in_valid & w_in_ready;
    w_xfer    = r_out_valid & out_ready;
    // A sample accepted in IDLE or HOLD always opens a new block.
    w_start   = w_accept & (r_state != S_ACCUM);
    // Zero length means the full 2^LEN_WIDTH samples.
    w_len_dec = (block_len == '0) ? {1'b1, {LEN_WIDTH{1'b0}}}
                                  : {1'b0, block_len};
    w_sum_ext = EXT_WIDTH'(r_acc) + EXT_WIDTH'(in_sum);
    w_new_acc = w_start ? ACC_WIDTH'(in_sum) : w_sum_ext[ACC_WIDTH-1:0];
    w_new_cnt = w_start ? CNT_WIDTH'(1) : (r_cnt + CNT_WIDTH'(1));
    w_new_ovf = w_start ? 1'b0 : (r_ovf | w_sum_ext[ACC_WIDTH]);
    w_new_len = w_start ? w_len_dec : r_len;
    w_done    = w_accept & (w_new_cnt == w_new_len);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = w_done ? S_HOLD : S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (w_done) begin
          w_state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (w_xfer) begin
          if (w_accept) begin
            w_state_nxt = w_done ? S_HOLD : S_ACCUM;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State-decoded outputs; in HOLD the input side follows out_ready.
  always_comb begin
    w_in_ready = 1'b1;
    w_busy     = 1'b0;
    case (r_state)
      S_ACCUM: w_busy = 1'b1;
      S_HOLD:  w_in_ready = out_ready;
      default: ;
    endcase
  end

  // Running block accumulator, sample count, latched length, sticky carry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_len <= '0;
      r_ovf <= 1'b0;
    end else if (w_accept) begin
      r_acc <= w_new_acc;
      r_cnt <= w_new_cnt;
      r_len <= w_new_len;
      r_ovf <= w_new_ovf;
    end
  end

  // Result registers: load on block completion, hold until transferred.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_acc   <= '0;
      r_out_count <= '0;
      r_out_ovf   <= 1'b0;
    end else if (w_done) begin
      r_out_valid <= 1'b1;
      r_out_acc   <= w_new_acc;
      r_out_count <= w_new_cnt;
      r_out_ovf   <= w_new_ovf;
    end else if (w_xfer) begin
      r_out_valid <= 1'b0;
    end
  end

  assign in_ready     = w_in_ready;
  assign busy         = w_busy;
  assign out_valid    = r_out_valid;
  assign out_acc      = r_out_acc;
  assign out_count    = r_out_count;
  assign out_overflow = r_out_ovf;

endmodule

// File: tb/tb_adder_sum_accumulator.sv
// Directed bench for adder_sum_accumulator: vector table plus
// hand-written multi-cycle sequences (backpressure, 256-sample blocks,
// carry-out, reset mid-block).
module tb_adder_sum_accumulator;

  localparam logic [56:0] BIG = 57'h1FFFFFFFFFFFFFF;

  logic        clk;
  logic        rst_n;

  // Default-width instance
  logic        a_in_valid;
  logic        a_in_ready;
  logic [56:0] a_in_sum;
  logic [7:0]  a_block_len;
  logic        a_out_valid;
  logic        a_out_ready;
  logic [63:0] a_out_acc;
  logic [8:0]  a_out_count;
  logic        a_out_ovf;
  logic        a_busy;

  // ACC_WIDTH == SUM_WIDTH instance for carry-out checks
  logic        b_in_valid;
  logic        b_in_ready;
  logic [56:0] b_in_sum;
  logic [7:0]  b_block_len;
  logic        b_out_valid;
  logic        b_out_ready;
  logic [56:0] b_out_acc;
  logic [8:0]  b_out_count;
  logic        b_out_ovf;
  logic        b_busy;

  int n_cmp;
  int n_bad;

  typedef struct {
    logic        v;
    logic [56:0] s;
    logic [7:0]  len;
    logic        ordy;
    logic        e_irdy;
    logic        e_ov;
    logic [63:0] e_acc;
    logic [8:0]  e_cnt;
    logic        e_ovf;
    logic        e_busy;
  } vec_t;

  vec_t tbl[$];

  adder_sum_accumulator #(.SUM_WIDTH(57), .ACC_WIDTH(64), .LEN_WIDTH(8)) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_sum(a_in_sum),
    .block_len(a_block_len), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_acc(a_out_acc), .out_count(a_out_count), .out_overflow(a_out_ovf),
    .busy(a_busy)
  );

  adder_sum_accumulator #(.SUM_WIDTH(57), .ACC_WIDTH(57), .LEN_WIDTH(8)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_sum(b_in_sum),
    .block_len(b_block_len), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_acc(b_out_acc), .out_count(b_out_count), .out_overflow(b_out_ovf),
    .busy(b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic ov, input logic [63:0] acc,
                       input logic [8:0] cnt, input logic ovf, input logic bsy);
    chk({tag, " out_valid"}, 64'(a_out_valid), 64'(ov));
    chk({tag, " out_acc"}, a_out_acc, acc);
    chk({tag, " out_count"}, 64'(a_out_count), 64'(cnt));
    chk({tag, " out_overflow"}, 64'(a_out_ovf), 64'(ovf));
    chk({tag, " busy"}, 64'(a_busy), 64'(bsy));
  endtask

  task automatic step_a(input logic v, input logic [56:0] s, input logic [7:0] len,
                        input logic ordy);
    a_in_valid  = v;
    a_in_sum    = s;
    a_block_len = len;
    a_out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  task automatic step_b(input logic v, input logic [56:0] s, input logic [7:0] len,
                        input logic ordy);
    b_in_valid  = v;
    b_in_sum    = s;
    b_block_len = len;
    b_out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic v, input logic [56:0] s, input logic [7:0] len,
                              input logic ordy, input logic irdy, input logic ov,
                              input logic [63:0] acc, input logic [8:0] cnt,
                              input logic ovf, input logic bsy);
    vec_t r;
    r.v = v; r.s = s; r.len = len; r.ordy = ordy;
    r.e_irdy = irdy; r.e_ov = ov; r.e_acc = acc; r.e_cnt = cnt;
    r.e_ovf = ovf; r.e_busy = bsy;
    return r;
  endfunction

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    a_in_valid = 1'b0; a_in_sum = '0; a_block_len = '0; a_out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_sum = '0; b_block_len = '0; b_out_ready = 1'b0;

    // 4-sample block, then drain
    tbl.push_back(mk(1'b1, 57'd10, 8'd4, 1'b1, 1'b1, 1'b0, 64'd0,   9'd0, 1'b0, 1'b1));
    tbl.push_back(mk(1'b1, 57'd20, 8'd4, 1'b1, 1'b1, 1'b0, 64'd0,   9'd0, 1'b0, 1'b1));
    tbl.push_back(mk(1'b1, 57'd30, 8'd4, 1'b1, 1'b1, 1'b0, 64'd0,   9'd0, 1'b0, 1'b1));
    tbl.push_back(mk(1'b1, 57'd40, 8'd4, 1'b1, 1'b1, 1'b1, 64'd100, 9'd4, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 57'd0,  8'd4, 1'b1, 1'b1, 1'b0, 64'd100, 9'd4, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 57'd0,  8'd3, 1'b0, 1'b1, 1'b0, 64'd100, 9'd4, 1'b0, 1'b0));
    // 3-sample block under backpressure
    tbl.push_back(mk(1'b1, 57'd1,  8'd3, 1'b0, 1'b1, 1'b0, 64'd100, 9'd4, 1'b0, 1'b1));
    tbl.push_back(mk(1'b1, 57'd2,  8'd3, 1'b0, 1'b1, 1'b0, 64'd100, 9'd4, 1'b0, 1'b1));
    tbl.push_back(mk(1'b1, 57'd3,  8'd3, 1'b0, 1'b1, 1'b1, 64'd6,   9'd3, 1'b0, 1'b0));
    for (int k = 0; k < 5; k++) begin
      tbl.push_back(mk(1'b1, 57'd99, 8'd3, 1'b0, 1'b0, 1'b1, 64'd6, 9'd3, 1'b0, 1'b0));
    end
    // zero-bubble restart on transfer; length change mid-block ignored
    tbl.push_back(mk(1'b1, 57'd50, 8'd2, 1'b1, 1'b1, 1'b0, 64'd6,  9'd3, 1'b0, 1'b1));
    tbl.push_back(mk(1'b1, 57'd7,  8'd9, 1'b1, 1'b1, 1'b1, 64'd57, 9'd2, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 57'd0,  8'd1, 1'b1, 1'b1, 1'b0, 64'd57, 9'd2, 1'b0, 1'b0));
    // single-sample streaming
    tbl.push_back(mk(1'b1, 57'd7,  8'd1, 1'b1, 1'b1, 1'b1, 64'd7,  9'd1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 57'd8,  8'd1, 1'b1, 1'b1, 1'b1, 64'd8,  9'd1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 57'd9,  8'd1, 1'b1, 1'b1, 1'b1, 64'd9,  9'd1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 57'd0,  8'd1, 1'b1, 1'b1, 1'b0, 64'd9,  9'd1, 1'b0, 1'b0));
    // single-sample block held by backpressure
    tbl.push_back(mk(1'b1, 57'd5,  8'd1, 1'b1, 1'b1, 1'b1, 64'd5,  9'd1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 57'd6,  8'd1, 1'b0, 1'b0, 1'b1, 64'd5,  9'd1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 57'd0,  8'd1, 1'b1, 1'b1, 1'b0, 64'd5,  9'd1, 1'b0, 1'b0));

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk_a("reset", 1'b0, 64'd0, 9'd0, 1'b0, 1'b0);
    chk("reset in_ready", 64'(a_in_ready), 64'd1);
    chk("reset b out_acc", 64'(b_out_acc), 64'd0);
    rst_n = 1'b1;

    // vector table
    for (int i = 0; i < tbl.size(); i++) begin
      a_in_valid  = tbl[i].v;
      a_in_sum    = tbl[i].s;
      a_block_len = tbl[i].len;
      a_out_ready = tbl[i].ordy;
      #1;
      chk($sformatf("row%0d in_ready", i), 64'(a_in_ready), 64'(tbl[i].e_irdy));
      @(posedge clk);
      #1;
      chk_a($sformatf("row%0d", i), tbl[i].e_ov, tbl[i].e_acc, tbl[i].e_cnt,
            tbl[i].e_ovf, tbl[i].e_busy);
    end

    // reset asserted mid-block discards the partial sum
    step_a(1'b1, 57'd5, 8'd4, 1'b1);
    step_a(1'b1, 57'd5, 8'd4, 1'b1);
    chk("midblock busy", 64'(a_busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk_a("in reset", 1'b0, 64'd0, 9'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk_a("in reset 2", 1'b0, 64'd0, 9'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    step_a(1'b1, 57'd1, 8'd2, 1'b1);
    step_a(1'b1, 57'd1, 8'd2, 1'b1);
    chk_a("post reset", 1'b1, 64'd2, 9'd2, 1'b0, 1'b0);
    step_a(1'b0, 57'd0, 8'd2, 1'b1);

    // wide sums: 2-sample block, then two back-to-back 256-sample blocks
    step_a(1'b1, BIG, 8'd2, 1'b1);
    step_a(1'b1, BIG, 8'd2, 1'b1);
    chk_a("big2", 1'b1, 64'h3FFFFFFFFFFFFFE, 9'd2, 1'b0, 1'b0);
    for (int i = 0; i < 512; i++) begin
      step_a(1'b1, BIG, ((i % 256) == 0) ? 8'd0 : 8'd5, 1'b1);
      if ((i % 256) == 255) begin
        chk_a($sformatf("blk256 end%0d", i), 1'b1, 64'hFFFFFFFFFFFFFF00, 9'd256, 1'b1, 1'b0);
      end else begin
        chk($sformatf("blk256 s%0d out_valid", i), 64'(a_out_valid), 64'd0);
      end
    end
    step_a(1'b0, 57'd0, 8'd0, 1'b1);
    chk("drain out_valid", 64'(a_out_valid), 64'd0);

    // carry out of a 57-bit accumulator, then cleared on the next block
    step_b(1'b1, BIG, 8'd2, 1'b1);
    step_b(1'b1, 57'd2, 8'd2, 1'b1);
    chk("ovf out_valid", 64'(b_out_valid), 64'd1);
    chk("ovf out_acc", 64'(b_out_acc), 64'd1);
    chk("ovf out_count", 64'(b_out_count), 64'd2);
    chk("ovf flag", 64'(b_out_ovf), 64'd1);
    step_b(1'b1, 57'd1, 8'd2, 1'b1);
    chk("ovf restart out_valid", 64'(b_out_valid), 64'd0);
    step_b(1'b1, 57'd1, 8'd2, 1'b1);
    chk("clr out_acc", 64'(b_out_acc), 64'd2);
    chk("clr flag", 64'(b_out_ovf), 64'd0);
    step_b(1'b0, 57'd0, 8'd2, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
